// File: rtl/audio_dsp_pkg.sv
// Shared audio DSP types, Q-format constants and arithmetic helpers.
// The FIR equalizer uses this package, and the IIR filter can share it.
package audio_dsp_pkg;

    typedef logic signed [17:0] coef_t;    // Q2.16 coefficient
    typedef logic signed [15:0] sample_t;  // audio sample
    typedef logic signed [33:0] prod_t;    // coef * sample, exact
    typedef logic signed [34:0] acc_t;     // sum of two products, exact

    localparam int      COEF_FRAC  = 16;
    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;
    localparam acc_t    ROUND_HALF = 35'sd32768;

    // Full-precision signed product of a coefficient and a sample.
    function automatic prod_t mul_coef(input coef_t c, input sample_t x);
        return prod_t'(c) * prod_t'(x);
    endfunction

    // Sign-extend a sample into accumulator width for range comparisons.
    function automatic acc_t widen_sample(input sample_t s);
        return acc_t'(s);
    endfunction

endpackage

// File: rtl/fir_eq_mod_if.sv
// Sample-strobed stream bus of the FIR equalizer: input strobe, sample and
// counter clear toward the filter; result strobe, sample, clip flag and clip
// counter back from it.
interface fir_eq_mod_if
    import audio_dsp_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             valid_i;
    sample_t          data_i;
    logic             clear_i;
    logic             valid_o;
    sample_t          data_o;
    logic             sat_o;
    logic [CNT_W-1:0] sat_count_o;

    modport master (
        output valid_i, data_i, clear_i,
        input  valid_o, data_o, sat_o, sat_count_o
    );

    modport slave (
        input  valid_i, data_i, clear_i,
        output valid_o, data_o, sat_o, sat_count_o
    );
endinterface

// File: rtl/round_sat_mod.sv
// Combinational Q.16 -> integer conversion: round half-up, then clip to
// the 16-bit sample range and flag when clipping happened.
module round_sat_mod
    import audio_dsp_pkg::*;
(
    input  acc_t    sum_i,
    output sample_t data_o,
    output logic    sat_o
);
    acc_t biased_s;
    acc_t shifted_s;

    // The bias cannot overflow because the sum of two products stays far
    // below the accumulator range. Arithmetic shift keeps the sign, which
    // makes +half then floor equal to round half-up.
    always_comb begin
        biased_s  = sum_i + ROUND_HALF;
        shifted_s = biased_s >>> COEF_FRAC;
        data_o    = shifted_s[15:0];
        sat_o     = 1'b0;
        if (shifted_s > widen_sample(SAMPLE_MAX)) begin
            data_o = SAMPLE_MAX;
            sat_o  = 1'b1;
        end else if (shifted_s < widen_sample(SAMPLE_MIN)) begin
            data_o = SAMPLE_MIN;
            sat_o  = 1'b1;
        end else begin
            data_o = shifted_s[15:0];
            sat_o  = 1'b0;
        end
    end
endmodule

// File: rtl/fir_eq_mod.sv
// First-order FIR equalizer y[n] = c0*x[n] + c1*x[n-1] with a two-stage
// pipeline. Stage 1 forms both products on accepted samples only, so the
// history advances per sample and not per clock. Stage 2 rounds, clips and
// registers the result. A sticky saturating counter tracks clipped results.
module fir_eq_mod
    import audio_dsp_pkg::*;
#(
    parameter coef_t COEF_C0 = 18'sd65536,
    parameter coef_t COEF_C1 = 18'sd0,
    parameter int    CNT_W   = 16
)(
    input  logic          clk_i,
    input  logic          reset_i,
    fir_eq_mod_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage 1 state
    prod_t   p0_q, p0_d;
    prod_t   p1_q, p1_d;
    sample_t x_d_q, x_d_d;
    logic    v1_q, v1_d;

    // Stage 2 / output state
    logic             valid_q, valid_d;
    sample_t          data_q, data_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    acc_t    sum_s;
    sample_t rnd_data_s;
    logic    rnd_sat_s;

    // Stage 1: compute products and advance the delay line on accepted samples only.
    always_comb begin
        p0_d  = p0_q;
        p1_d  = p1_q;
        x_d_d = x_d_q;
        v1_d  = bus.valid_i;
        if (bus.valid_i) begin
            p0_d  = mul_coef(COEF_C0, bus.data_i);
            p1_d  = mul_coef(COEF_C1, x_d_q);
            x_d_d = bus.data_i;
        end else begin
            p0_d  = p0_q;
            p1_d  = p1_q;
            x_d_d = x_d_q;
        end
    end

    assign sum_s = acc_t'(p0_q) + acc_t'(p1_q);

    round_sat_mod u_round_sat (
        .sum_i  (sum_s),
        .data_o (rnd_data_s),
        .sat_o  (rnd_sat_s)
    );

    // Stage 2: present a new result when stage 1 held one, otherwise hold data and drop sat.
    always_comb begin
        valid_d = v1_q;
        data_d  = data_q;
        sat_d   = 1'b0;
        if (v1_q) begin
            data_d = rnd_data_s;
            sat_d  = rnd_sat_s;
        end else begin
            data_d = data_q;
            sat_d  = 1'b0;
        end
    end

    // Clip counter: counts each presented clipped result, sticks at all-ones, clear has priority.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (valid_q && sat_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline, delay line and counter registers; reset flushes in-flight samples.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            p0_q    <= 34'sd0;
            p1_q    <= 34'sd0;
            x_d_q   <= 16'sd0;
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 16'sd0;
            sat_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            x_d_q   <= x_d_d;
            v1_q    <= v1_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_q;
    assign bus.sat_o       = sat_q;
    assign bus.sat_count_o = cnt_q;
endmodule

// File: tb/tb_fir_eq_mod.sv
// Directed bench for fir_eq_mod: four instances with different coefficient
// sets (pass-through, inverse of a pole, saturating gain, half gain).
module tb_fir_eq_mod;
    import audio_dsp_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fir_eq_mod_if #(.CNT_W(16)) if_pt  ();
    fir_eq_mod_if #(.CNT_W(16)) if_inv ();
    fir_eq_mod_if #(.CNT_W(2))  if_sat ();
    fir_eq_mod_if #(.CNT_W(16)) if_rnd ();

    fir_eq_mod #(.COEF_C0(18'sd65536),  .COEF_C1(18'sd0),      .CNT_W(16))
        dut_pt  (.clk_i(clk), .reset_i(rst), .bus(if_pt.slave));
    fir_eq_mod #(.COEF_C0(18'sd65536),  .COEF_C1(-18'sd32768), .CNT_W(16))
        dut_inv (.clk_i(clk), .reset_i(rst), .bus(if_inv.slave));
    fir_eq_mod #(.COEF_C0(18'sd131071), .COEF_C1(18'sd0),      .CNT_W(2))
        dut_sat (.clk_i(clk), .reset_i(rst), .bus(if_sat.slave));
    fir_eq_mod #(.COEF_C0(18'sd32768),  .COEF_C1(18'sd0),      .CNT_W(16))
        dut_rnd (.clk_i(clk), .reset_i(rst), .bus(if_rnd.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_pt.valid_i  = 1'b0; if_pt.data_i  = 16'sd0; if_pt.clear_i  = 1'b0;
        if_inv.valid_i = 1'b0; if_inv.data_i = 16'sd0; if_inv.clear_i = 1'b0;
        if_sat.valid_i = 1'b0; if_sat.data_i = 16'sd0; if_sat.clear_i = 1'b0;
        if_rnd.valid_i = 1'b0; if_rnd.data_i = 16'sd0; if_rnd.clear_i = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", int'(if_pt.valid_o), 0);
        chk("rst_data",  int'(if_pt.data_o), 0);
        chk("rst_sat",   int'(if_pt.sat_o), 0);
        chk("rst_count", int'(if_pt.sat_count_o), 0);
        rst = 1'b0;

        // Pass-through, 2-cycle latency
        if_pt.valid_i = 1'b1; if_pt.data_i = 16'sd1000;
        tick();
        chk("pt_lat1_valid", int'(if_pt.valid_o), 0);
        if_pt.data_i = -16'sd2000;
        tick();
        chk("pt_o0_valid", int'(if_pt.valid_o), 1);
        chk("pt_o0_data",  int'(if_pt.data_o), 1000);
        chk("pt_o0_sat",   int'(if_pt.sat_o), 0);
        if_pt.valid_i = 1'b0;
        tick();
        chk("pt_o1_valid", int'(if_pt.valid_o), 1);
        chk("pt_o1_data",  int'(if_pt.data_o), -2000);
        tick();
        chk("pt_idle_valid", int'(if_pt.valid_o), 0);
        chk("pt_idle_hold",  int'(if_pt.data_o), -2000);

        // Inverse of a pole: 1000, 1000, 0 -> 1000, 500, -500
        if_inv.valid_i = 1'b1; if_inv.data_i = 16'sd1000;
        tick();
        if_inv.data_i = 16'sd1000;
        tick();
        chk("inv_o0", int'(if_inv.data_o), 1000);
        if_inv.data_i = 16'sd0;
        tick();
        chk("inv_o1", int'(if_inv.data_o), 500);
        if_inv.valid_i = 1'b0;
        tick();
        chk("inv_o2_valid", int'(if_inv.valid_o), 1);
        chk("inv_o2", int'(if_inv.data_o), -500);
        tick();
        chk("inv_idle_valid", int'(if_inv.valid_o), 0);

        // Valid gaps: history counts accepted samples, not cycles
        if_inv.valid_i = 1'b1; if_inv.data_i = 16'sd1000;
        tick();
        if_inv.valid_i = 1'b0;
        tick();
        chk("gap_first", int'(if_inv.data_o), 1000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_hold_valid", int'(if_inv.valid_o), 0);
            chk("gap_hold_data",  int'(if_inv.data_o), 1000);
            chk("gap_hold_sat",   int'(if_inv.sat_o), 0);
        end
        if_inv.valid_i = 1'b1; if_inv.data_i = 16'sd1000;
        tick();
        if_inv.valid_i = 1'b0;
        tick();
        chk("gap_second_valid", int'(if_inv.valid_o), 1);
        chk("gap_second", int'(if_inv.data_o), 500);

        // Saturation high
        if_sat.valid_i = 1'b1; if_sat.data_i = 16'sd20000;
        tick();
        if_sat.valid_i = 1'b0;
        tick();
        chk("sat_hi_data", int'(if_sat.data_o), 32767);
        chk("sat_hi_flag", int'(if_sat.sat_o), 1);
        tick();
        chk("sat_hi_count", int'(if_sat.sat_count_o), 1);
        chk("sat_flag_idle", int'(if_sat.sat_o), 0);

        // Saturation low
        if_sat.valid_i = 1'b1; if_sat.data_i = -16'sd32768;
        tick();
        if_sat.valid_i = 1'b0;
        tick();
        chk("sat_lo_data", int'(if_sat.data_o), -32768);
        chk("sat_lo_flag", int'(if_sat.sat_o), 1);
        tick();
        chk("sat_lo_count", int'(if_sat.sat_count_o), 2);

        // Clear coincident with a sat event: clear wins
        if_sat.valid_i = 1'b1; if_sat.data_i = 16'sd20000;
        tick();
        if_sat.valid_i = 1'b0;
        tick();
        chk("sat_clr_flag", int'(if_sat.sat_o), 1);
        if_sat.clear_i = 1'b1;
        tick();
        if_sat.clear_i = 1'b0;
        chk("sat_clr_count", int'(if_sat.sat_count_o), 0);
        tick();
        chk("sat_clr_stay", int'(if_sat.sat_count_o), 0);

        // Counter sticks at all-ones (2-bit counter, four events)
        if_sat.valid_i = 1'b1; if_sat.data_i = 16'sd20000;
        for (int i = 0; i < 4; i++) tick();
        if_sat.valid_i = 1'b0;
        tick();
        chk("sat_cnt_at_max", int'(if_sat.sat_count_o), 3);
        tick();
        chk("sat_cnt_sticky", int'(if_sat.sat_count_o), 3);

        // Rounding with gain 0.5: 3, -3, 1, -1 -> 2, -1, 1, 0
        if_rnd.valid_i = 1'b1; if_rnd.data_i = 16'sd3;
        tick();
        if_rnd.data_i = -16'sd3;
        tick();
        chk("rnd_p3", int'(if_rnd.data_o), 2);
        if_rnd.data_i = 16'sd1;
        tick();
        chk("rnd_m3", int'(if_rnd.data_o), -1);
        if_rnd.data_i = -16'sd1;
        tick();
        chk("rnd_p1", int'(if_rnd.data_o), 1);
        if_rnd.valid_i = 1'b0;
        tick();
        chk("rnd_m1", int'(if_rnd.data_o), 0);
        chk("rnd_m1_valid", int'(if_rnd.valid_o), 1);
        chk("rnd_m1_sat", int'(if_rnd.sat_o), 0);

        // Reset mid-stream, pulsed between clock edges
        if_inv.valid_i = 1'b1; if_inv.data_i = 16'sd1000;
        tick();
        if_inv.valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", int'(if_inv.valid_o), 0);
        chk("mid_rst_data", int'(if_inv.data_o), 0);
        rst = 1'b0;
        tick();
        chk("flush_valid0", int'(if_inv.valid_o), 0);
        tick();
        chk("flush_valid1", int'(if_inv.valid_o), 0);
        if_inv.valid_i = 1'b1; if_inv.data_i = 16'sd1000;
        tick();
        if_inv.valid_i = 1'b0;
        tick();
        chk("post_rst_valid", int'(if_inv.valid_o), 1);
        chk("post_rst_xd_clear", int'(if_inv.data_o), 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
